uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
- Downstream consumer of the UART receive FIFO.
- Pops received bytes via rd_uart/r_data/rx_empty and parses 4-byte command frames: SYNC, ADDR, DATA, CHK.
- Presents each valid command on a valid/ready interface to the register-file / control logic.
- Flags checksum errors and inter-byte timeouts, and keeps a saturating error count.

Parameters:
- DBIT, 8, byte width; must match the UART data width.
- SYNC, 8'hA5, frame start byte.
- TIMEOUT, 50000, max idle clk cycles allowed between bytes inside a frame.
- TO_BIT, 16, counter width; 2**TO_BIT > TIMEOUT.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets the block).
- rx_empty  in  1  receive FIFO empty flag.
- r_data  in  DBIT  receive FIFO head byte; valid while rx_empty=0.
- rd_uart  out  1  FIFO pop; byte r_data is consumed in the cycle rd_uart=1.
- cmd_valid  out  1  command available.
- cmd_ready  in  1  consumer accepts the command.
- cmd_addr  out  DBIT  command address.
- cmd_data  out  DBIT  command data.
- chk_err  out  1  one-cycle pulse on checksum mismatch.
- to_err  out  1  one-cycle pulse on inter-byte timeout.
- err_cnt  out  8  saturating count of chk_err + to_err events.

Behaviour:
- Reset (async, reset=0):
  - state=HUNT; cmd_valid=0, cmd_addr=0, cmd_data=0, chk_err=0, to_err=0, err_cnt=0, timeout counter=0.
  - rd_uart=0 while reset is asserted.
  - A reset in mid-frame discards the partial frame.
- rd_uart is combinational: rd_uart = !rx_empty && state in {HUNT, ADDR, DATA, CHK}. It is never asserted in OUT.
- A byte is accepted in any cycle with rd_uart=1, and is sampled from r_data in that same cycle.
- State transitions:
  - HUNT:
    - Accepted byte == SYNC -> ADDR.
    - Any other byte is silently dropped; stay in HUNT with no error.
  - ADDR: accepted byte -> latch into addr register -> DATA.
  - DATA: accepted byte -> latch into data register -> CHK.
  - CHK: compute (addr + data) mod 2**DBIT (carry discarded), then:
    - Equal to the accepted byte -> load cmd_addr/cmd_data, set cmd_valid=1 -> OUT.
    - Not equal -> chk_err=1 for the next cycle only -> HUNT.
  - OUT:
    - cmd_valid stays 1 and cmd_addr/cmd_data stay stable until cmd_ready=1.
    - Transfer happens on the edge where cmd_valid && cmd_ready; next cycle cmd_valid=0 and state=HUNT.
    - The FIFO is not popped while in OUT (back-pressure is held in the FIFO).
- Latency: cmd_valid rises on the clock edge that consumes the CHK byte.
- Timeout counter:
  - Active only in ADDR/DATA/CHK; cleared on every accepted byte and on entry to HUNT/OUT.
  - Increments on each cycle in those states with no accepted byte.
  - When the counter == TIMEOUT-1 and no byte is accepted that cycle: next state HUNT, to_err=1 for one cycle, counter cleared.
- Simultaneous events:
  - A byte accepted in the expiry cycle wins; no timeout, and normal parsing continues.
  - A SYNC byte arriving in ADDR/DATA/CHK is treated as ordinary data; there is no resynchronisation mid-frame.
- err_cnt:
  - +1 on each chk_err or to_err pulse; saturates at 255 and does not wrap.
  - chk_err and to_err are never asserted in the same cycle.
- Outputs cmd_valid, cmd_addr, cmd_data, chk_err, to_err and err_cnt are all registered.

Test Plan:
- Good frame: FIFO holds A5,12,34,46 with cmd_ready=1 -> 4 pops in 4 consecutive cycles; cmd_valid=1 for 1 cycle with cmd_addr=12, cmd_data=34; chk_err=0, err_cnt=0.
- Back-pressure: frame A5,10,20,30 followed by A5,01,02,03 queued, cmd_ready=0 for 20 cycles -> cmd_valid held with addr=10/data=20; rd_uart=0 throughout; after cmd_ready=1, the second command is delivered as addr=01/data=02.
- Checksum wrap and error: A5,F0,20,10 -> valid (0xF0+0x20=0x110, keeps 0x10). A5,F0,20,11 -> chk_err 1-cycle pulse, err_cnt=1, no cmd_valid.
- Hunt and garbage: bytes 00,FF,5A,A5,01,01,02 -> leading three bytes dropped with no error; one command addr=01/data=01.
- Timeout (TIMEOUT=10): A5,07 then FIFO empty -> to_err pulses exactly 10 cycles after the 07 pop, err_cnt=1. A byte arriving at the expiry cycle instead -> no to_err.
- Reset/saturation: assert reset=0 after A5,33 -> state HUNT, all outputs 0. Inject 300 bad frames -> err_cnt=255 and stays there.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - pops UART RX FIFO bytes and parses SYNC/ADDR/DATA/CHK command frames
module uart_cmd_parser #(
    parameter int              DBIT    = 8,
    parameter logic [DBIT-1:0] SYNC    = 8'hA5,
    parameter int              TIMEOUT = 50000,
    parameter int              TO_BIT  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_empty,
    input  logic [DBIT-1:0] r_data,
    output logic            rd_uart,
    output logic            cmd_valid,
    input  logic            cmd_ready,
    output logic [DBIT-1:0] cmd_addr,
    output logic [DBIT-1:0] cmd_data,
    output logic            chk_err,
    output logic            to_err,
    output logic [7:0]      err_cnt
);

    typedef enum logic [2:0] {
        S_HUNT = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_CHK  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    localparam logic [TO_BIT-1:0] TO_LAST = TO_BIT'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [DBIT-1:0]   addr_q, addr_d;
    logic [DBIT-1:0]   data_q, data_d;
    logic [DBIT-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DBIT-1:0]   cmd_data_q, cmd_data_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              chk_err_q, chk_err_d;
    logic              to_err_q, to_err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [TO_BIT-1:0] to_cnt_q, to_cnt_d;
    logic [DBIT-1:0]   sum;
    logic              accept;
    logic              expired;

    // Gated by reset so the FIFO is never popped while the block is held in reset.
    assign rd_uart = reset && !rx_empty && (state_q != S_OUT);
    assign accept  = rd_uart;
    assign sum     = addr_q + data_q;
    assign expired = !accept && (to_cnt_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        cmd_valid_d = cmd_valid_q;
        chk_err_d   = 1'b0;
        to_err_d    = 1'b0;
        to_cnt_d    = '0;

        case (state_q)
            S_HUNT: begin
                if (accept && r_data == SYNC) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR, S_DATA, S_CHK: begin
                if (accept) begin
                    if (state_q == S_ADDR) begin
                        addr_d  = r_data;
                        state_d = S_DATA;
                    end else if (state_q == S_DATA) begin
                        data_d  = r_data;
                        state_d = S_CHK;
                    end else if (r_data == sum) begin
                        cmd_addr_d  = addr_q;
                        cmd_data_d  = data_q;
                        cmd_valid_d = 1'b1;
                        state_d     = S_OUT;
                    end else begin
                        chk_err_d = 1'b1;
                        state_d   = S_HUNT;
                    end
                end else if (expired) begin
                    to_err_d = 1'b1;
                    state_d  = S_HUNT;
                end else begin
                    to_cnt_d = to_cnt_q + TO_BIT'(1);
                end
            end
            S_OUT: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = S_HUNT;
                end
            end
            default: begin
                state_d = S_HUNT;
            end
        endcase

        // Counts in the same edge as the pulse so err_cnt is current while the pulse is visible.
        err_cnt_d = err_cnt_q;
        if ((chk_err_d || to_err_d) && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_HUNT;
            addr_q      <= '0;
            data_q      <= '0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            chk_err_q   <= 1'b0;
            to_err_q    <= 1'b0;
            err_cnt_q   <= '0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            cmd_valid_q <= cmd_valid_d;
            chk_err_q   <= chk_err_d;
            to_err_q    <= to_err_d;
            err_cnt_q   <= err_cnt_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_data  = cmd_data_q;
    assign chk_err   = chk_err_q;
    assign to_err    = to_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - scoreboard bench for uart_cmd_parser with a behavioural RX FIFO
module tb_uart_cmd_parser;

    localparam int TO = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_empty = 1'b1;
    logic [7:0] r_data = 8'h00;
    logic       rd_uart;
    logic       cmd_valid;
    logic       cmd_ready = 1'b1;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       chk_err;
    logic       to_err;
    logic [7:0] err_cnt;

    uart_cmd_parser #(
        .DBIT(8), .SYNC(8'hA5), .TIMEOUT(TO), .TO_BIT(16)
    ) dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data),
        .rd_uart(rd_uart), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .chk_err(chk_err),
        .to_err(to_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [7:0] a;
        logic [7:0] d;
    } ev_t;

    logic [7:0] fifo[$];
    ev_t        exp_q[$];
    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int last_pop = 0;
    int pops = 0;
    int mdl_err = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    function automatic void refresh();
        rx_empty = (fifo.size() == 0);
        r_data   = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endfunction

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        refresh();
    endtask

    task automatic exp_cmd(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back('{0, a, d});
    endtask

    task automatic exp_err(input int kind);
        exp_q.push_back('{kind, 8'h00, 8'h00});
    endtask

    // FIFO model: the byte seen by the DUT at the edge is removed just after it.
    initial begin
        logic do_pop;
        forever begin
            @(posedge clk);
            cyc++;
            do_pop = rd_uart;
            #1;
            if (do_pop) begin
                if (fifo.size() > 0) void'(fifo.pop_front());
                pops++;
                last_pop = cyc;
                refresh();
            end
        end
    end

    task automatic observe(input int kind, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event_kind", kind, -1);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind == 0 && e.kind == 0) begin
                chk("cmd_addr", a, e.a);
                chk("cmd_data", d, e.d);
            end
            if (kind != 0 && e.kind == kind) begin
                if (mdl_err < 255) mdl_err++;
                chk("err_cnt", err_cnt, mdl_err);
                if (kind == 2) chk("to_delay", cyc - last_pop, TO);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                if (chk_err) observe(1, 8'h00, 8'h00);
                if (to_err) observe(2, 8'h00, 8'h00);
                if (cmd_valid && cmd_ready) observe(0, cmd_addr, cmd_data);
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(fifo.size() == 0 && exp_q.size() == 0 && !cmd_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            $display("FAIL drain_timeout: pending=%0d fifo=%0d after %0d cycles", exp_q.size(), fifo.size(), n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_fifo_empty(input int budget);
        int n;
        n = 0;
        while (fifo.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            $display("FAIL fifo_wait_timeout: fifo=%0d required 0", fifo.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        push(8'h77);
        #1;
        chk({tag, "_rd_uart"}, rd_uart, 0);
        chk({tag, "_cmd_valid"}, cmd_valid, 0);
        chk({tag, "_cmd_addr"}, cmd_addr, 0);
        chk({tag, "_cmd_data"}, cmd_data, 0);
        chk({tag, "_chk_err"}, chk_err, 0);
        chk({tag, "_to_err"}, to_err, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
        fifo.delete();
        refresh();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  p0;
        bit  stable;

        repeat (3) @(negedge clk);
        check_reset_outputs("init");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Good frame: four back-to-back pops, command visible right after the CHK pop.
        exp_cmd(8'h12, 8'h34);
        p0 = pops;
        push(8'hA5); push(8'h12); push(8'h34); push(8'h46);
        repeat (4) @(negedge clk);
        chk("good_pops", pops - p0, 4);
        chk("good_valid", cmd_valid, 1);
        chk("good_err_cnt", err_cnt, 0);
        wait_idle(200);

        // Back-pressure
        cmd_ready = 1'b0;
        exp_cmd(8'h10, 8'h20);
        exp_cmd(8'h01, 8'h02);
        push(8'hA5); push(8'h10); push(8'h20); push(8'h30);
        push(8'hA5); push(8'h01); push(8'h02); push(8'h03);
        repeat (4) @(negedge clk);
        chk("bp_valid", cmd_valid, 1);
        p0 = pops;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!cmd_valid || cmd_addr != 8'h10 || cmd_data != 8'h20 || rd_uart) stable = 1'b0;
        end
        chk("bp_hold_stable", stable, 1);
        chk("bp_no_pops", pops - p0, 0);
        chk("bp_fifo_left", fifo.size(), 4);
        cmd_ready = 1'b1;
        wait_idle(200);

        // Checksum wrap, then checksum error
        exp_cmd(8'hF0, 8'h20);
        exp_err(1);
        push(8'hA5); push(8'hF0); push(8'h20); push(8'h10);
        push(8'hA5); push(8'hF0); push(8'h20); push(8'h11);
        wait_idle(200);
        chk("chk_err_cnt", err_cnt, 1);

        // Garbage before SYNC is dropped silently
        exp_cmd(8'h01, 8'h01);
        push(8'h00); push(8'hFF); push(8'h5A); push(8'hA5);
        push(8'h01); push(8'h01); push(8'h02);
        wait_idle(200);
        chk("hunt_err_cnt", err_cnt, 1);

        // Inter-byte timeout
        exp_err(2);
        push(8'hA5); push(8'h07);
        wait_idle(200);
        chk("to_err_cnt", err_cnt, 2);

        // Byte arriving in the expiry cycle wins over the timeout
        exp_cmd(8'h07, 8'h08);
        push(8'hA5); push(8'h07);
        wait_fifo_empty(50);
        repeat (TO - 1) @(negedge clk);
        push(8'h08); push(8'h0F);
        wait_idle(200);
        chk("expiry_err_cnt", err_cnt, 2);

        // Reset in mid-frame discards the partial frame
        push(8'hA5); push(8'h33);
        wait_fifo_empty(50);
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("midrst");
        mdl_err = 0;
        @(negedge clk);
        reset = 1'b1;
        exp_cmd(8'h44, 8'h55);
        push(8'hA5); push(8'h44); push(8'h55); push(8'h99);
        wait_idle(200);

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            exp_err(1);
            push(8'hA5); push(8'h00); push(8'h00); push(8'h01);
        end
        wait_idle(3000);
        chk("sat_err_cnt", err_cnt, 255);
        chk("sat_no_valid", cmd_valid, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
